// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic register pipeline.
package pipe_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned DEPTH_DEF = 4;

    // Bits needed to count 0..n inclusive.
    function automatic int unsigned clog2p1(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline slot: a valid bit plus a data word that only updates on valid loads.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    // Data is captured only with a valid item, so bubbles never disturb the held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_data  <= RESET_VAL;
        end else if (flush) begin
            q_valid <= 1'b0;
            q_data  <= RESET_VAL;
        end else if (load) begin
            q_valid <= d_valid;
            if (d_valid) begin
                q_data <= d_data;
            end
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic register chain of DEPTH stages with valid/ready at both ends, flush and occupancy.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = WIDTH_DEF,
    parameter int unsigned      DEPTH     = DEPTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [clog2p1(DEPTH)-1:0]    occupancy
);

    localparam int unsigned OCC_W = clog2p1(DEPTH);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] load;

    // Go chain walked from the output back: a stage may advance if any later slot is free or the sink drains.
    always_comb begin : adv_chain
        logic go;
        go   = out_ready;
        load = '0;
        for (int i = int'(DEPTH) - 1; i > 0; i--) begin
            go      = go || !valid_q[i];
            load[i] = go;
        end
        in_ready = !flush && (!valid_q[0] || go);
        load[0]  = in_ready;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            pipe_stage #(
                .WIDTH    (WIDTH),
                .RESET_VAL(RESET_VAL)
            ) u_stage (
                .clk    (clk),
                .rst    (rst),
                .flush  (flush),
                .load   (load[i]),
                .d_valid(in_valid),
                .d_data (in_data),
                .q_valid(valid_q[i]),
                .q_data (data_q[i])
            );
        end else begin : g_body
            pipe_stage #(
                .WIDTH    (WIDTH),
                .RESET_VAL(RESET_VAL)
            ) u_stage (
                .clk    (clk),
                .rst    (rst),
                .flush  (flush),
                .load   (load[i]),
                .d_valid(valid_q[i-1]),
                .d_data (data_q[i-1]),
                .q_valid(valid_q[i]),
                .q_data (data_q[i])
            );
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

    // Popcount of the valid bits.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            occupancy = occupancy + OCC_W'(valid_q[i]);
        end
    end

endmodule
